// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Sums blocks of BLOCK_LEN unsigned products into an ACC_W-bit accumulator.
//   Each finished block sum lands in a one-deep output buffer. The next block
//   can keep accumulating while that result waits to be drained.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   clear               synchronous flush, same effect as rst
//   in_valid/in_ready   product handshake; in_product is unsigned IN_W
//   out_valid/out_ready result handshake
//   out_sum             block sum modulo 2^ACC_W
//   out_overflow        block sum did not fit in ACC_W bits
//   count               products accepted so far in the current block
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter  int IN_W      = 32,
  parameter  int ACC_W     = 40,
  parameter  int BLOCK_LEN = 16,
  localparam int CNT_W     = $clog2(BLOCK_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] count
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  logic             w_last;
  logic             w_accept;
  logic             w_drain;
  logic [ACC_W:0]   w_sum;   // one extra bit to catch the carry out

  assign w_last   = (r_count == CNT_W'(BLOCK_LEN - 1));
  // Only the closing product of a block can stall: it needs the buffer free,
  // or freeing up in this same cycle.
  assign in_ready = !rst && !clear && !(w_last && r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;
  assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(in_product);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_drain)
        r_out_valid <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          // Completion wins over a same-cycle drain: buffer reloads.
          r_out_sum   <= w_sum[ACC_W-1:0];
          r_out_ovf   <= r_ovf | w_sum[ACC_W];
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_count     <= '0;
        end else begin
          r_acc   <= w_sum[ACC_W-1:0];
          r_ovf   <= r_ovf | w_sum[ACC_W];
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_ovf;
  assign count        = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Two instances share one stimulus stream: ACC_W=40 (wide, never overflows
// with four 32-bit products) and ACC_W=33 (overflow reachable).
module tb_product_accumulator;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_product = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [39:0] out_sum_a;
  logic [1:0]  count_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [32:0] out_sum_b;
  logic [1:0]  count_b;

  product_accumulator #(.IN_W(32), .ACC_W(40), .BLOCK_LEN(BL)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_overflow(out_ovf_a), .count(count_a));

  product_accumulator #(.IN_W(32), .ACC_W(33), .BLOCK_LEN(BL)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_overflow(out_ovf_b), .count(count_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: blocks of products, plain arithmetic
  typedef struct {
    logic [39:0] s40;
    bit          o40;
    logic [32:0] s33;
    bit          o33;
  } res_t;

  res_t            exp_q[$];
  int              nprod   = 0;
  longint unsigned blk_sum = 0;
  int              ndrain  = 0;

  always @(negedge clk) begin
    if (rst) begin
      nprod = 0; blk_sum = 0; exp_q.delete();
    end else if (clear) begin
      chk("clr_in_ready", 64'(in_ready_a), 0);
      nprod = 0; blk_sum = 0; exp_q.delete();
    end else begin
      bit full, acc, drn;
      full = (exp_q.size() != 0);
      chk("mon_out_valid_a", 64'(out_valid_a), 64'(full));
      chk("mon_out_valid_b", 64'(out_valid_b), 64'(full));
      chk("mon_count",       64'(count_a), 64'(nprod));
      chk("mon_in_ready_a",  64'(in_ready_a), 64'(!(nprod == BL-1 && full && !out_ready)));
      chk("mon_in_ready_b",  64'(in_ready_b), 64'(!(nprod == BL-1 && full && !out_ready)));
      acc = in_valid && (nprod != BL-1 || !full || out_ready);
      drn = full && out_ready;
      if (drn) begin
        chk("mon_sum_a", 64'(out_sum_a), 64'(exp_q[0].s40));
        chk("mon_ovf_a", 64'(out_ovf_a), 64'(exp_q[0].o40));
        chk("mon_sum_b", 64'(out_sum_b), 64'(exp_q[0].s33));
        chk("mon_ovf_b", 64'(out_ovf_b), 64'(exp_q[0].o33));
        void'(exp_q.pop_front());
        ndrain++;
      end
      if (acc) begin
        blk_sum += 64'(in_product);
        nprod++;
        if (nprod == BL) begin
          res_t r;
          r.s40 = blk_sum[39:0]; r.o40 = (blk_sum >= (64'd1 << 40));
          r.s33 = blk_sum[32:0]; r.o33 = (blk_sum >= (64'd1 << 33));
          exp_q.push_back(r);
          nprod = 0; blk_sum = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  bit rnd_on = 0;
  always begin
    @(posedge clk); #1;
    if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] p);
    bit ok = 0;
    int n = 0;
    in_valid = 1'b1; in_product = p;
    while (!ok && n < 100) begin
      @(negedge clk); ok = in_ready_a;
      @(posedge clk); #1; n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 64'(out_valid_a), 0);
    chk("rst_out_sum",   64'(out_sum_a), 0);
    chk("rst_count",     64'(count_a), 0);
    chk("rst_in_ready",  64'(in_ready_a), 0);
    step(); step(); rst = 1'b0; step();

    // 1) basic block, result visible for exactly one cycle
    out_ready = 1'b1;
    send(1); send(2); send(3); send(4);
    chk("t1_valid", 64'(out_valid_a), 1);
    chk("t1_sum",   64'(out_sum_a), 10);
    chk("t1_ovf",   64'(out_ovf_a), 0);
    chk("t1_count", 64'(count_a), 0);
    step();
    chk("t1_valid_gone", 64'(out_valid_a), 0);

    // 2) overflow in the 33-bit instance, sticky flag cleared per block
    repeat (4) send(32'hFFFF_FFFF);
    chk("t2_sum33", 64'(out_sum_b), 64'h1_FFFF_FFFC);
    chk("t2_ovf33", 64'(out_ovf_b), 1);
    chk("t2_sum40", 64'(out_sum_a), 64'h3_FFFF_FFFC);
    chk("t2_ovf40", 64'(out_ovf_a), 0);
    repeat (4) send(1);
    chk("t2_sum33_next", 64'(out_sum_b), 4);
    chk("t2_ovf33_next", 64'(out_ovf_b), 0);
    step();

    // 3) backpressure on the closing product only
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    send(5); send(6); send(7);
    chk("t3_count3", 64'(count_a), 3);
    in_valid = 1'b1; in_product = 8;
    repeat (3) begin
      #1;
      chk("t3_stall",   64'(in_ready_a), 0);
      chk("t3_sum_hold", 64'(out_sum_a), 10);
      step();
    end
    out_ready = 1'b1;
    #1 chk("t3_ready_comb", 64'(in_ready_a), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_sum_b",   64'(out_sum_a), 26);
    chk("t3_valid_b", 64'(out_valid_a), 1);
    step();

    // 4) asynchronous reset mid-block with a full buffer
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    send(1); send(1);
    #1 rst = 1'b1;
    #1;
    chk("t4_valid", 64'(out_valid_a), 0);
    chk("t4_sum",   64'(out_sum_a), 0);
    chk("t4_count", 64'(count_a), 0);
    step(); rst = 1'b0; out_ready = 1'b1;
    send(2); send(2); send(2); send(2);
    chk("t4_sum_after", 64'(out_sum_a), 8);
    step();

    // 5) synchronous clear drops the product offered with it
    send(1); send(2); send(3);
    in_valid = 1'b1; in_product = 9; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_count", 64'(count_a), 0);
    chk("t5_valid", 64'(out_valid_a), 0);
    send(1); send(2); send(3); send(4);
    chk("t5_sum", 64'(out_sum_a), 10);
    step();

    // 6) random stalls on both sides against the model
    ndrain = 0;
    rnd_on = 1;
    for (int i = 0; i < 1000; i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) step();
      if ($urandom_range(0, 1) != 0) send(32'hF000_0000 | $urandom);
      else                           send($urandom);
    end
    rnd_on = 0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("t6_blocks", 64'(ndrain), 250);
    chk("t6_empty",  64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    chk("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 16x16 combinational multiplier.
- Accepts a stream of 32-bit products over a valid/ready handshake and sums each block of BLOCK_LEN products into a wide accumulator.
- Each completed block sum goes into a one-deep output buffer with its own valid/ready handshake, so the next block can start accumulating while the previous result waits to be drained.
- Together with the multiplier this forms a dot-product / MAC path.

Parameters:
- IN_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator and output width; must be >= IN_W.
- BLOCK_LEN, 16, products per block; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of all state; same effect as rst, applied on the clock edge.
- in_valid  input  1  in_product is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  IN_W  product from the multiplier, unsigned.
- out_valid  output  1  out_sum/out_overflow hold a completed block.
- out_ready  input  1  downstream takes the buffered result.
- out_sum  output  ACC_W  block sum, modulo 2^ACC_W.
- out_overflow  output  1  block sum exceeded ACC_W bits.
- count  output  clog2(BLOCK_LEN)  products accepted so far in the current block.

Behaviour:
- Reset (rst high, asynchronous) or clear (synchronous, highest priority):
  - acc = 0, count = 0, ovf = 0.
  - out_valid = 0, out_sum = 0, out_overflow = 0.
  - A product offered in the same cycle is dropped.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output drain = out_valid & out_ready.
  - in_product must be held stable while in_valid=1 and in_ready=0.
  - in_ready is low while rst or clear is high.
- Accumulation, on accept with count < BLOCK_LEN-1:
  - acc <= acc + zero-extended in_product, truncated to ACC_W.
  - ovf is set sticky if the addition carries out of bit ACC_W-1.
  - count <= count+1.
- Block completion, on accept with count == BLOCK_LEN-1:
  - out_sum <= acc + in_product (ACC_W-truncated).
  - out_overflow <= ovf | carry.
  - out_valid <= 1.
  - acc, ovf, count <= 0.
  - Latency: out_valid rises the cycle after the final accept.
- Output buffer:
  - out_valid stays high and out_sum/out_overflow stay stable until drained.
  - On drain with no simultaneous completion, out_valid <= 0.
  - On drain in the same cycle as a completion, the buffer reloads with the new result and out_valid stays 1.
- Backpressure rule:
  - in_ready = !(count == BLOCK_LEN-1 & out_valid & !out_ready).
  - Only the final product of a block stalls, and only when the buffer is full and not draining.
  - Products 0..BLOCK_LEN-2 of the next block are always accepted.
  - in_ready depends combinationally on out_ready; this path is permitted.
- count is registered. It wraps BLOCK_LEN-1 -> 0 only on completion, never otherwise.
- in_valid=0 holds all state.
- No products are lost or duplicated under any handshake interleaving.
- Arithmetic is unsigned only.

Test Plan (BLOCK_LEN=4, ACC_W=40 unless stated):
- Reset, then products 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 for exactly one cycle, starting the cycle after the 4th accept; out_sum=10; out_overflow=0; count back to 0.
- ACC_W=33: four products of 0xFFFF_FFFF -> out_sum=0x1_FFFF_FFFC, out_overflow=1; the next block 1,1,1,1 -> out_sum=4, out_overflow=0 (sticky flag cleared per block).
- Hold out_ready=0 after block A (sum 10), stream block B = 5,6,7,8 -> B's first three products are accepted; in_ready=0 while 8 is offered; out_sum stays 10. Raise out_ready -> 8 is accepted in that same cycle; next cycle out_sum=26, out_valid=1.
- Assert rst asynchronously mid-block (count=2) with out_valid=1 -> all outputs 0 immediately, without a clock edge; after release, block 2,2,2,2 gives out_sum=8.
- Pulse clear for one cycle with in_valid=1 at count=3 -> that product is dropped, count=0, out_valid=0; the following block 1,2,3,4 gives out_sum=10.
- Random in_valid/out_ready stalls over 1000 products against a software model -> every block sum and overflow flag matches, in order, with no drops or repeats.
